axi_write_burst_sequencer: RTL and testbench

// Write-channel controller of the AXI slave core, between the write address FIFO and the APB master.

---
 rtl/axi_write_burst_sequencer.sv | 176 +++++++++++++++++
 tb/tb_axi_write_burst_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_write_burst_sequencer.sv
// Write-channel burst sequencer: pops one AW entry, expands it into per-beat
// APB writes paired with W beats, and returns one B response per burst.
module axi_write_burst_sequencer #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 6
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_fifo_empty,
    output logic                o_fifo_rd_en,
    input  logic [ADDR_W-1:0]   i_fifo_addr,
    input  logic [ID_W-1:0]     i_fifo_id,
    input  logic [7:0]          i_fifo_len,
    input  logic [2:0]          i_fifo_size,
    input  logic [1:0]          i_fifo_burst,
    input  logic [2:0]          i_fifo_prot,
    input  logic [DATA_W-1:0]   i_wdata,
    input  logic [DATA_W/8-1:0] i_wstrb,
    input  logic                i_wlast,
    input  logic                i_wvalid,
    output logic                o_wready,
    output logic                o_apb_req,
    output logic [ADDR_W-1:0]   o_apb_addr,
    output logic [DATA_W-1:0]   o_apb_wdata,
    output logic [DATA_W/8-1:0] o_apb_strb,
    output logic [2:0]          o_apb_prot,
    input  logic                i_apb_done,
    input  logic                i_apb_err,
    output logic                o_bvalid,
    input  logic                i_bready,
    output logic [ID_W-1:0]     o_bid,
    output logic [1:0]          o_bresp,
    output logic                o_busy
);

    localparam int STRB_W = DATA_W / 8;
    localparam logic [2:0] MAX_SIZE = 3'($clog2(STRB_W));

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_LOAD,
        S_DATA,
        S_XFER,
        S_RESP
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [ADDR_W-1:0] r_addr;
    logic [ID_W-1:0]   r_id;
    logic [7:0]        r_len;
    logic [2:0]        r_size;
    logic [1:0]        r_burst;
    logic [2:0]        r_prot;
    logic [7:0]        r_beat;
    logic              r_err;
    logic              r_illegal;
    logic [DATA_W-1:0] r_wdata;
    logic [STRB_W-1:0] r_wstrb;

    logic              w_illegal;
    logic              w_last_beat;
    logic              w_w_hs;
    logic              w_xfer_done;
    logic [ADDR_W-1:0] w_bytes;
    logic [ADDR_W-1:0] w_mask;
    logic [ADDR_W-1:0] w_incr;
    logic [ADDR_W-1:0] w_next_addr;

    always_comb begin
        w_illegal = 1'b0;
        if (i_fifo_size > MAX_SIZE)   w_illegal = 1'b1;
        if (i_fifo_burst == 2'b11)    w_illegal = 1'b1;
        if (i_fifo_burst == BURST_WRAP) begin
            case (i_fifo_len)
                8'd1, 8'd3, 8'd7, 8'd15: ;
                default: w_illegal = 1'b1;
            endcase
        end
    end

    assign w_last_beat = (r_beat == r_len);
    assign w_w_hs      = (r_state == S_DATA) && i_wvalid;
    // Illegal bursts skip the APB side and leave XFER after a single cycle.
    assign w_xfer_done = (r_state == S_XFER) && (r_illegal || i_apb_done);

    assign w_bytes = ADDR_W'(1) << r_size;
    assign w_mask  = (ADDR_W'({1'b0, r_len} + 9'd1) << r_size) - ADDR_W'(1);
    assign w_incr  = r_addr + w_bytes;

    always_comb begin
        w_next_addr = w_incr;
        if (r_burst == BURST_FIXED)
            w_next_addr = r_addr;
        else if (r_burst == BURST_WRAP)
            w_next_addr = (r_addr & ~w_mask) | (w_incr & w_mask);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (!i_fifo_empty) w_next = S_POP;
            S_POP:  w_next = S_LOAD;
            S_LOAD: w_next = S_DATA;
            S_DATA: if (i_wvalid) w_next = S_XFER;
            S_XFER: if (w_xfer_done) w_next = w_last_beat ? S_RESP : S_DATA;
            S_RESP: if (i_bready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_addr    <= '0;
            r_id      <= '0;
            r_len     <= '0;
            r_size    <= '0;
            r_burst   <= '0;
            r_prot    <= '0;
            r_beat    <= '0;
            r_err     <= 1'b0;
            r_illegal <= 1'b0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else begin
            if (r_state == S_LOAD) begin
                r_addr    <= i_fifo_addr;
                r_id      <= i_fifo_id;
                r_len     <= i_fifo_len;
                r_size    <= i_fifo_size;
                r_burst   <= i_fifo_burst;
                r_prot    <= i_fifo_prot;
                r_beat    <= '0;
                r_err     <= w_illegal;
                r_illegal <= w_illegal;
            end
            if (w_w_hs) begin
                r_wdata <= i_wdata;
                r_wstrb <= i_wstrb;
                // WLAST must coincide exactly with the final counted beat.
                if (i_wlast != w_last_beat) r_err <= 1'b1;
            end
            if (w_xfer_done) begin
                if (!r_illegal && i_apb_err) r_err <= 1'b1;
                r_addr <= w_next_addr;
                if (!w_last_beat) r_beat <= r_beat + 8'd1;
            end
        end
    end

    // The pop strobe is a decode of the state register so it is one cycle
    // wide and low during reset; FIFO data is then valid in LOAD.
    assign o_fifo_rd_en = (r_state == S_POP);
    assign o_wready     = (r_state == S_DATA);
    assign o_apb_req    = (r_state == S_XFER) && !r_illegal;
    assign o_apb_addr   = r_addr;
    assign o_apb_wdata  = r_wdata;
    assign o_apb_strb   = r_wstrb;
    assign o_apb_prot   = r_prot;
    assign o_bvalid     = (r_state == S_RESP);
    assign o_bid        = r_id;
    assign o_bresp      = ((r_state == S_RESP) && r_err) ? 2'b10 : 2'b00;
    assign o_busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_axi_write_burst_sequencer.sv
// Bench for axi_write_burst_sequencer: FIFO/APB/W models around the DUT and
// a burst-level reference for addresses, data and responses.
module tb_axi_write_burst_sequencer;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 6;
    localparam int SW = DW / 8;

    typedef struct {
        logic [AW-1:0] addr;
        logic [IW-1:0] id;
        logic [7:0]    len;
        logic [2:0]    size;
        logic [1:0]    burst;
        logic [2:0]    prot;
    } aw_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          fifo_empty = 1'b1;
    logic          rd_en;
    logic [AW-1:0] fifo_addr = '0;
    logic [IW-1:0] fifo_id = '0;
    logic [7:0]    fifo_len = '0;
    logic [2:0]    fifo_size = '0;
    logic [1:0]    fifo_burst = '0;
    logic [2:0]    fifo_prot = '0;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic          wlast, wvalid, wready;
    logic          apb_req;
    logic [AW-1:0] apb_addr;
    logic [DW-1:0] apb_wdata;
    logic [SW-1:0] apb_strb;
    logic [2:0]    apb_prot;
    logic          apb_done = 1'b0;
    logic          apb_err = 1'b0;
    logic          bvalid, bready;
    logic [IW-1:0] bid;
    logic [1:0]    bresp;
    logic          busy;

    axi_write_burst_sequencer #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_fifo_empty(fifo_empty), .o_fifo_rd_en(rd_en),
        .i_fifo_addr(fifo_addr), .i_fifo_id(fifo_id), .i_fifo_len(fifo_len),
        .i_fifo_size(fifo_size), .i_fifo_burst(fifo_burst), .i_fifo_prot(fifo_prot),
        .i_wdata(wdata), .i_wstrb(wstrb), .i_wlast(wlast), .i_wvalid(wvalid),
        .o_wready(wready),
        .o_apb_req(apb_req), .o_apb_addr(apb_addr), .o_apb_wdata(apb_wdata),
        .o_apb_strb(apb_strb), .o_apb_prot(apb_prot),
        .i_apb_done(apb_done), .i_apb_err(apb_err),
        .o_bvalid(bvalid), .i_bready(bready), .o_bid(bid), .o_bresp(bresp),
        .o_busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Address FIFO model: entry appears on its outputs the cycle after the pop.
    aw_t aw_q[$];
    aw_t fe;
    always @(negedge clk) begin
        if (rd_en && aw_q.size() > 0) begin
            fe = aw_q.pop_front();
            fifo_addr = fe.addr; fifo_id = fe.id; fifo_len = fe.len;
            fifo_size = fe.size; fifo_burst = fe.burst; fifo_prot = fe.prot;
        end
        fifo_empty = (aw_q.size() == 0);
    end

    // APB completer: answers each request after apb_delay cycles and logs it.
    int            apb_delay = 0;
    int            apb_cnt = 0;
    logic [15:0]   err_plan = '0;
    logic [AW-1:0] log_addr[$];
    logic [DW-1:0] log_data[$];
    logic [SW-1:0] log_strb[$];
    logic [2:0]    log_prot[$];
    always @(negedge clk) begin
        if (!rst_n) begin
            apb_done = 1'b0; apb_err = 1'b0; apb_cnt = 0;
        end else if (apb_done) begin
            apb_done = 1'b0; apb_err = 1'b0;
        end else if (apb_req) begin
            if (apb_cnt >= apb_delay) begin
                apb_err = (log_addr.size() < 16) ? err_plan[log_addr.size()] : 1'b0;
                apb_done = 1'b1;
                apb_cnt = 0;
                log_addr.push_back(apb_addr); log_data.push_back(apb_wdata);
                log_strb.push_back(apb_strb); log_prot.push_back(apb_prot);
            end else apb_cnt++;
        end
    end

    function automatic logic is_legal(input aw_t a);
        if (a.size > 3'($clog2(SW))) return 1'b0;
        if (a.burst == 2'b11) return 1'b0;
        if (a.burst == 2'b10 && !(a.len == 1 || a.len == 3 || a.len == 7 || a.len == 15))
            return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [AW-1:0] beat_addr(input aw_t a, input int i);
        longint unsigned bytes, total, base, start;
        bytes = longint'(1) << a.size;
        start = longint'(a.addr);
        case (a.burst)
            2'b00:   return a.addr;
            2'b10: begin
                total = (longint'(a.len) + 1) * bytes;
                base  = start - (start % total);
                return AW'(base + ((start - base + longint'(i) * bytes) % total));
            end
            default: return AW'(start + longint'(i) * bytes);
        endcase
    endfunction

    function automatic void clear_log();
        log_addr.delete(); log_data.delete(); log_strb.delete(); log_prot.delete();
    endfunction

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One full burst: W beats, APB comparison, B response with optional stall.
    task automatic run_burst(input aw_t a, input logic [15:0] errs, input int bad_last,
                             input int hold, input bit push);
        logic [DW-1:0] wd[16];
        logic [SW-1:0] ws[16];
        int beats, nexp, t;
        logic legal, exp_err;
        clear_log();
        err_plan = errs;
        if (push) aw_q.push_back(a);
        beats = int'(a.len) + 1;
        legal = is_legal(a);
        nexp = legal ? beats : 0;
        exp_err = !legal || (bad_last >= 0);
        for (int i = 0; i < beats; i++) begin
            wd[i] = $urandom;
            ws[i] = SW'($urandom_range(0, (1 << SW) - 1));
            if (legal && errs[i]) exp_err = 1'b1;
        end
        for (int i = 0; i < beats; i++) begin
            wvalid = 1'b0;
            wait_neg($urandom_range(0, 2));
            wvalid = 1'b1; wdata = wd[i]; wstrb = ws[i];
            wlast = (i == beats - 1) ^ (i == bad_last);
            t = 0;
            while (!wready && t < 200) begin @(negedge clk); t++; end
            chk("w_accept", wready, 1'b1);
            @(negedge clk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        t = 0;
        while (!bvalid && t < 400) begin @(negedge clk); t++; end
        chk("bvalid", bvalid, 1'b1);
        chk("apb_count", log_addr.size(), nexp);
        for (int i = 0; i < nexp && i < log_addr.size(); i++) begin
            chk("apb_addr", log_addr[i], beat_addr(a, i));
            chk("apb_wdata", log_data[i], wd[i]);
            chk("apb_strb", log_strb[i], ws[i]);
            chk("apb_prot", log_prot[i], a.prot);
        end
        chk("bid", bid, a.id);
        chk("bresp", bresp, exp_err ? 2'b10 : 2'b00);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_bvalid", bvalid, 1'b1);
            chk("hold_bid", bid, a.id);
            chk("hold_bresp", bresp, exp_err ? 2'b10 : 2'b00);
            chk("hold_no_pop", rd_en, 1'b0);
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        chk("b_done_idle", busy, 1'b0);
        chk("b_done_bvalid", bvalid, 1'b0);
    endtask

    function automatic aw_t mk(input logic [AW-1:0] addr, input logic [7:0] len,
                               input logic [2:0] size, input logic [1:0] burst);
        aw_t a;
        a.addr = addr; a.len = len; a.size = size; a.burst = burst;
        a.id = IW'($urandom); a.prot = 3'($urandom);
        return a;
    endfunction

    initial begin
        aw_t a, b;
        int t;
        rst_n = 1'b0; wvalid = 1'b0; wlast = 1'b0; wdata = '0; wstrb = '0; bready = 1'b0;
        wait_neg(3);
        chk("rst_rd_en", rd_en, 1'b0);
        chk("rst_wready", wready, 1'b0);
        chk("rst_apb_req", apb_req, 1'b0);
        chk("rst_apb_addr", apb_addr, '0);
        chk("rst_bvalid", bvalid, 1'b0);
        chk("rst_bresp", bresp, 2'b00);
        chk("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        wait_neg(2);

        run_burst(mk(32'h1000, 8'd3, 3'd2, 2'b01), 16'h0, -1, 0, 1'b1);
        run_burst(mk(32'h1008, 8'd3, 3'd2, 2'b10), 16'h0, -1, 0, 1'b1);
        run_burst(mk(32'h2000, 8'd1, 3'd2, 2'b00), 16'h0, -1, 0, 1'b1);
        apb_delay = 2;
        run_burst(mk(32'h1000, 8'd3, 3'd2, 2'b01), 16'h0004, -1, 0, 1'b1);
        apb_delay = 0;
        run_burst(mk(32'h4000, 8'd1, 3'd2, 2'b11), 16'h0, -1, 0, 1'b1);
        run_burst(mk(32'h5000, 8'd0, 3'd3, 2'b01), 16'h0, -1, 0, 1'b1);
        run_burst(mk(32'h6000, 8'd2, 3'd1, 2'b10), 16'h0, -1, 0, 1'b1);
        run_burst(mk(32'h7000, 8'd2, 3'd2, 2'b01), 16'h0, 1, 0, 1'b1);
        run_burst(mk(32'h7100, 8'd2, 3'd0, 2'b01), 16'h0, 2, 0, 1'b1);
        run_burst(mk(32'hFFFF_FFF8, 8'd3, 3'd2, 2'b01), 16'h0, -1, 0, 1'b1);
        run_burst(mk(32'h0000_0035, 8'd7, 3'd1, 2'b10), 16'h0, -1, 0, 1'b1);

        // B stall with the next entry already waiting in the FIFO.
        a = mk(32'h8000, 8'd1, 3'd2, 2'b01);
        b = mk(32'h9000, 8'd2, 3'd2, 2'b01);
        aw_q.push_back(a);
        aw_q.push_back(b);
        run_burst(a, 16'h0, -1, 5, 1'b0);
        run_burst(b, 16'h0, -1, 0, 1'b0);

        for (int k = 0; k < 24; k++) begin
            logic [1:0] bu;
            logic [7:0] ln;
            bu = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            ln = 8'($urandom_range(0, 15));
            if (bu == 2'b10 && $urandom_range(0, 3) != 0) ln = 8'((1 << $urandom_range(1, 4)) - 1);
            apb_delay = $urandom_range(0, 3);
            run_burst(mk($urandom, ln, 3'($urandom_range(0, 3)), bu),
                      16'($urandom & $urandom & $urandom),
                      ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, int'(ln))) : -1,
                      $urandom_range(0, 2), 1'b1);
        end

        // Reset while an APB transfer is outstanding.
        apb_delay = 6;
        clear_log();
        aw_q.push_back(mk(32'h3000, 8'd3, 3'd2, 2'b01));
        t = 0;
        while (!wready && t < 100) begin @(negedge clk); t++; end
        chk("rst_test_wready", wready, 1'b1);
        wvalid = 1'b1; wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wlast = 1'b0;
        @(negedge clk);
        wvalid = 1'b0;
        t = 0;
        while (!apb_req && t < 100) begin @(negedge clk); t++; end
        chk("rst_test_xfer", apb_req, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("midrst_apb_req", apb_req, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        @(negedge clk);
        chk("midrst_apb_addr", apb_addr, '0);
        chk("midrst_wdata", apb_wdata, '0);
        chk("midrst_bvalid", bvalid, 1'b0);
        chk("midrst_bid", bid, '0);
        chk("midrst_wready", wready, 1'b0);
        chk("midrst_rd_en", rd_en, 1'b0);
        rst_n = 1'b1;
        apb_delay = 0;
        wait_neg(6);
        chk("post_rst_no_b", bvalid, 1'b0);
        chk("post_rst_idle", busy, 1'b0);
        run_burst(mk(32'h1000, 8'd3, 3'd2, 2'b01), 16'h0, -1, 0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
